issue_scoreboard: RTL and testbench

- One-entry issue stage between the instruction decoder and the execute stage.
- Accepts decoded instructions (sources, destination, operand types, opCode, argument_value, pc) over a valid/ready handshake.
- Tracks in-flight destination registers in a busy scoreboard and holds an instruction until its RAW/WAW hazards clear.
- Provides flush sequencing: drain in-flight writes before restarting.

---
 rtl/issue_scoreboard.sv | 125 ++++++++++++
 tb/tb_issue_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// One-entry issue stage with a register busy scoreboard, RAW/WAW hold and flush drain.
// Optional stall counter enabled by defining ISSUE_STALL_COUNTER_EN.
module issue_scoreboard #(
  parameter int REGISTER_WIDTH = 4,
  parameter int OPCODE_WIDTH   = 6,
  parameter int PC_WIDTH       = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic [REGISTER_WIDTH-1:0]   source1,
  input  logic [REGISTER_WIDTH-1:0]   source2,
  input  logic [REGISTER_WIDTH-1:0]   destination,
  input  logic [1:0]                  source1_type,
  input  logic [1:0]                  source2_type,
  input  logic [1:0]                  destination_type,
  input  logic [OPCODE_WIDTH-1:0]     opCode,
  input  logic [REGISTER_WIDTH-1:0]   argument_value,
  input  logic [PC_WIDTH-1:0]         pc,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [REGISTER_WIDTH-1:0]   iss_source1,
  output logic [REGISTER_WIDTH-1:0]   iss_source2,
  output logic [REGISTER_WIDTH-1:0]   iss_destination,
  output logic [1:0]                  iss_source1_type,
  output logic [1:0]                  iss_source2_type,
  output logic [1:0]                  iss_destination_type,
  output logic [OPCODE_WIDTH-1:0]     iss_opCode,
  output logic [REGISTER_WIDTH-1:0]   iss_argument_value,
  output logic [PC_WIDTH-1:0]         iss_pc,
  input  logic                        wb_valid,
  input  logic [REGISTER_WIDTH-1:0]   wb_destination,
  input  logic                        flush,
  output logic [2**REGISTER_WIDTH-1:0] busy_mask,
  output logic [15:0]                 stall_cycles
);
  localparam int NREG = 2**REGISTER_WIDTH;
  localparam logic [1:0] T_REG = 2'b01;

  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] src1;
    logic [REGISTER_WIDTH-1:0] src2;
    logic [REGISTER_WIDTH-1:0] dst;
    logic [1:0]                t1;
    logic [1:0]                t2;
    logic [1:0]                td;
    logic [OPCODE_WIDTH-1:0]   op;
    logic [REGISTER_WIDTH-1:0] arg;
    logic [PC_WIDTH-1:0]       pc;
  } instr_t;

  typedef enum logic [1:0] {EMPTY, FULL, FLUSH_WAIT} state_t;

  state_t          state;
  instr_t          held, dec_in;
  logic [NREG-1:0] busy, busy_nxt, wb_clr, eff, set_vec;
  logic            hazard, iss_fire, dec_fire;

  assign dec_in = '{src1: source1, src2: source2, dst: destination,
                    t1: source1_type, t2: source2_type, td: destination_type,
                    op: opCode, arg: argument_value, pc: pc};

  // A writeback landing this cycle already releases its register for the hazard check.
  assign wb_clr = wb_valid ? (NREG'(1) << wb_destination) : '0;
  assign eff    = busy & ~wb_clr;
  assign hazard = (held.t1 == T_REG && eff[held.src1]) ||
                  (held.t2 == T_REG && eff[held.src2]) ||
                  (held.td == T_REG && eff[held.dst]);

  assign iss_valid = ~reset & ~flush & (state == FULL) & ~hazard;
  assign iss_fire  = iss_valid & iss_ready;
  assign dec_ready = ~reset & ~flush & ((state == EMPTY) | ((state == FULL) & iss_fire));
  assign dec_fire  = dec_valid & dec_ready;

  // Set wins over a same-cycle clear; register 0 can never be busy.
  assign set_vec  = (iss_fire && held.td == T_REG && held.dst != '0) ? (NREG'(1) << held.dst) : '0;
  assign busy_nxt = ((busy & ~wb_clr) | set_vec) & ~NREG'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      held  <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        state <= (busy == '0) ? EMPTY : FLUSH_WAIT;
      end else begin
        case (state)
          EMPTY:      if (dec_fire) begin held <= dec_in; state <= FULL; end
          FULL:       if (dec_fire) held <= dec_in;
                      else if (iss_fire) state <= EMPTY;
          FLUSH_WAIT: if (busy == '0) state <= EMPTY;
          default:    state <= EMPTY;
        endcase
      end
    end
  end

  assign busy_mask            = busy;
  assign iss_source1          = held.src1;
  assign iss_source2          = held.src2;
  assign iss_destination      = held.dst;
  assign iss_source1_type     = held.t1;
  assign iss_source2_type     = held.t2;
  assign iss_destination_type = held.td;
  assign iss_opCode           = held.op;
  assign iss_argument_value   = held.arg;
  assign iss_pc               = held.pc;

`ifdef ISSUE_STALL_COUNTER_EN
  logic [15:0] stall_q;
  always_ff @(posedge clock) begin
    if (reset)
      stall_q <= '0;
    else if (state == FULL && hazard && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: per-cycle comparison against a hold/busy model
// plus hand-computed literal pins at key points of each scenario.
module tb_issue_scoreboard;
  localparam int NR = 16;
  localparam logic [1:0] N = 2'b00, R = 2'b01, I = 2'b10, M = 2'b11;
`ifdef ISSUE_STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, dec_valid, dec_ready, iss_valid, iss_ready, wb_valid, flush;
  logic [3:0]  source1, source2, destination, argument_value, wb_destination;
  logic [1:0]  source1_type, source2_type, destination_type;
  logic [5:0]  opCode;
  logic [15:0] pc;
  logic [3:0]  iss_source1, iss_source2, iss_destination, iss_argument_value;
  logic [1:0]  iss_source1_type, iss_source2_type, iss_destination_type;
  logic [5:0]  iss_opCode;
  logic [15:0] iss_pc, busy_mask, stall_cycles;

  issue_scoreboard dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .source1(source1), .source2(source2), .destination(destination),
    .source1_type(source1_type), .source2_type(source2_type), .destination_type(destination_type),
    .opCode(opCode), .argument_value(argument_value), .pc(pc),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_source1(iss_source1), .iss_source2(iss_source2), .iss_destination(iss_destination),
    .iss_source1_type(iss_source1_type), .iss_source2_type(iss_source2_type),
    .iss_destination_type(iss_destination_type), .iss_opCode(iss_opCode),
    .iss_argument_value(iss_argument_value), .iss_pc(iss_pc),
    .wb_valid(wb_valid), .wb_destination(wb_destination), .flush(flush),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0] s1, s2, d, arg; logic [1:0] t1, t2, td; logic [5:0] op; logic [15:0] pc;
  } ins_t;

  bit   started = 0, mheld = 0, mdrain = 0;
  bit   mbusy [NR];
  int   mstall = 0;
  ins_t mi;

  function automatic bit busy_eff(input logic [3:0] r);
    return r != 0 && mbusy[r] && !(wb_valid && wb_destination == r);
  endfunction
  function automatic bit m_haz();
    return (mi.t1 == R && busy_eff(mi.s1)) || (mi.t2 == R && busy_eff(mi.s2)) ||
           (mi.td == R && busy_eff(mi.d));
  endfunction
  function automatic bit m_iv();
    return !reset && !flush && mheld && !m_haz();
  endfunction
  function automatic bit m_dr();
    return !reset && !flush && !mdrain && (!mheld || (m_iv() && iss_ready));
  endfunction
  function automatic logic [15:0] m_busy();
    logic [15:0] v = '0;
    for (int k = 0; k < NR; k++) v[k] = mbusy[k];
    return v;
  endfunction
  function automatic ins_t cur_dec();
    ins_t x;
    x.s1 = source1; x.s2 = source2; x.d = destination; x.arg = argument_value;
    x.t1 = source1_type; x.t2 = source2_type; x.td = destination_type;
    x.op = opCode; x.pc = pc;
    return x;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      started <= 1; mheld <= 0; mdrain <= 0; mstall <= 0;
      for (int k = 0; k < NR; k++) mbusy[k] <= 0;
    end else begin
      if (CNT_EN && mheld && m_haz() && mstall < 65535) mstall <= mstall + 1;
      for (int k = 1; k < NR; k++)
        if (m_iv() && iss_ready && mi.td == R && mi.d == k) mbusy[k] <= 1;
        else if (wb_valid && wb_destination == k) mbusy[k] <= 0;
      if (flush) begin
        mheld <= 0; mdrain <= (m_busy() != 0);
      end else if (mdrain) begin
        if (m_busy() == 0) mdrain <= 0;
      end else if (dec_valid && m_dr()) begin
        mheld <= 1; mi <= cur_dec();
      end else if (m_iv() && iss_ready) begin
        mheld <= 0;
      end
    end
  end

  // ---------------- compare ----------------
  int ntests = 0, nfail = 0;
  logic [4:0]  lcare = '0;   // [0]iss_valid [1]dec_ready [2]busy_mask [3]iss_pc [4]stall_cycles
  logic        l_iv, l_dr;
  logic [15:0] l_busy, l_pc, l_stall;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk("iss_valid", 64'(iss_valid), 64'(m_iv()));
      chk("dec_ready", 64'(dec_ready), 64'(m_dr()));
      chk("busy_mask", 64'(busy_mask), 64'(m_busy()));
      chk("stall_cycles", 64'(stall_cycles), 64'(mstall));
      if (mheld)
        chk("iss_data",
            64'({iss_source1, iss_source2, iss_destination, iss_source1_type, iss_source2_type,
                 iss_destination_type, iss_opCode, iss_argument_value, iss_pc}),
            64'({mi.s1, mi.s2, mi.d, mi.t1, mi.t2, mi.td, mi.op, mi.arg, mi.pc}));
      if (lcare[0]) chk("lit_iss_valid", 64'(iss_valid), 64'(l_iv));
      if (lcare[1]) chk("lit_dec_ready", 64'(dec_ready), 64'(l_dr));
      if (lcare[2]) chk("lit_busy_mask", 64'(busy_mask), 64'(l_busy));
      if (lcare[3]) chk("lit_iss_pc", 64'(iss_pc), 64'(l_pc));
      if (lcare[4]) chk("lit_stall", 64'(stall_cycles), 64'(l_stall));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1; lcare = '0;
  endtask
  task automatic lit(input logic [4:0] c, input logic iv, input logic dr,
                     input logic [15:0] b, input logic [15:0] p, input logic [15:0] s);
    lcare = c; l_iv = iv; l_dr = dr; l_busy = b; l_pc = p; l_stall = s;
  endtask
  task automatic dec(input logic [3:0] s1, input logic [1:0] t1, input logic [3:0] s2,
                     input logic [1:0] t2, input logic [3:0] d, input logic [1:0] td,
                     input logic [15:0] p);
    dec_valid = 1; source1 = s1; source1_type = t1; source2 = s2; source2_type = t2;
    destination = d; destination_type = td; pc = p; opCode = p[7:2] ^ 6'h15; argument_value = p[5:2];
  endtask

  initial begin
    reset = 1; dec_valid = 0; iss_ready = 0; wb_valid = 0; wb_destination = 0; flush = 0;
    source1 = 0; source2 = 0; destination = 0; source1_type = 0; source2_type = 0;
    destination_type = 0; opCode = 0; argument_value = 0; pc = 0;
    tick(); tick();
    reset = 0;
    lit(5'b11111, 0, 1, 16'h0000, 16'h0000, 16'd0);
    // r1 = r2 + r3
    iss_ready = 1;
    dec(2, R, 3, R, 1, R, 16'd0); tick();
    dec_valid = 0; lit(5'b01101, 1, 0, 16'h0000, 16'd0, 0); tick();
    lit(5'b00111, 0, 1, 16'h0002, 0, 0);
    // r4 = r1 + imm : RAW on r1
    dec(1, R, 5, I, 4, R, 16'd4); tick();
    dec_valid = 0; lit(5'b00111, 0, 0, 16'h0002, 0, 0); tick();
    lit(5'b00111, 0, 0, 16'h0002, 0, 0); tick();
    wb_valid = 1; wb_destination = 1; lit(5'b01111, 1, 1, 16'h0002, 16'd4, 0); tick();
    wb_valid = 0; lit(5'b10111, 0, 1, 16'h0010, 0, CNT_EN ? 16'd2 : 16'd0);
    // wb to r0 and to a non-busy register change nothing
    wb_valid = 1; wb_destination = 0; tick();
    wb_destination = 9; lit(5'b00100, 0, 0, 16'h0010, 0, 0); tick();
    wb_destination = 4; lit(5'b00100, 0, 0, 16'h0010, 0, 0); tick();
    wb_valid = 0; lit(5'b00100, 0, 0, 16'h0000, 0, 0);
    // back-to-back independent, then WAW on r7 resolved by same-cycle wb (set wins)
    dec(0, I, 0, N, 6, R, 16'd0); tick();
    dec(0, I, 0, N, 7, R, 16'd4); lit(5'b01011, 1, 1, 0, 16'd0, 0); tick();
    dec(0, I, 0, N, 8, R, 16'd8); lit(5'b01011, 1, 1, 0, 16'd4, 0); tick();
    dec(0, I, 0, N, 7, R, 16'd44); lit(5'b01011, 1, 1, 0, 16'd8, 0); tick();
    dec_valid = 0; lit(5'b01111, 0, 0, 16'h01C0, 16'd44, 0); tick();
    wb_valid = 1; wb_destination = 7; lit(5'b01011, 1, 1, 0, 16'd44, 0); tick();
    wb_valid = 0; lit(5'b00111, 0, 1, 16'h01C0, 0, 0);
    wb_valid = 1; wb_destination = 6; tick();
    wb_destination = 7; tick();
    wb_destination = 8; tick();
    wb_valid = 0; lit(5'b00100, 0, 0, 16'h0000, 0, 0);
    // execute back-pressure for 3 cycles
    iss_ready = 0;
    dec(0, M, 0, N, 9, R, 16'd12); tick();
    dec(0, I, 0, N, 10, R, 16'd16);
    repeat (3) begin lit(5'b01011, 1, 0, 0, 16'd12, 0); tick(); end
    iss_ready = 1; lit(5'b01011, 1, 1, 0, 16'd12, 0); tick();
    dec_valid = 0; lit(5'b01111, 1, 1, 16'h0200, 16'd16, 0); tick();
    lit(5'b00100, 0, 0, 16'h0600, 0, 0);
    wb_valid = 1; wb_destination = 9; tick();
    wb_destination = 10; tick();
    wb_valid = 0;
    // flush with r5 busy: drain until wb r5, EMPTY one cycle after busy is 0
    dec(0, I, 0, N, 5, R, 16'd20); tick();
    dec(5, R, 0, N, 11, R, 16'd24); tick();
    dec_valid = 0; flush = 1; lit(5'b00111, 0, 0, 16'h0020, 0, 0); tick();
    flush = 0; lit(5'b00111, 0, 0, 16'h0020, 0, 0); tick();
    lit(5'b00011, 0, 0, 0, 0, 0); tick();
    wb_valid = 1; wb_destination = 5; lit(5'b00011, 0, 0, 0, 0, 0); tick();
    wb_valid = 0; lit(5'b00111, 0, 0, 16'h0000, 0, 0); tick();
    lit(5'b00111, 0, 1, 16'h0000, 0, 0);
    // reset mid-operation with a held instruction and a busy register
    dec(0, I, 0, N, 3, R, 16'd36); tick();
    dec(3, R, 3, R, 13, R, 16'd40); tick();
    dec_valid = 0; reset = 1; lit(5'b00011, 0, 0, 0, 0, 0); tick();
    reset = 0; lit(5'b11111, 0, 1, 16'h0000, 16'd0, 16'd0);
    // 7-cycle RAW stall on r1
    dec(0, I, 0, N, 1, R, 16'd28); tick();
    dec(1, R, 0, N, 2, R, 16'd32); tick();
    dec_valid = 0; repeat (7) tick();
    wb_valid = 1; wb_destination = 1; lit(5'b11011, 1, 1, 0, 16'd32, CNT_EN ? 16'd7 : 16'd0); tick();
    wb_valid = 0; lit(5'b00100, 0, 0, 16'h0004, 0, 0); tick();
    wb_valid = 1; wb_destination = 2; tick();
    wb_valid = 0; lit(5'b00100, 0, 0, 16'h0000, 0, 0); tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
